mannix_ddr_read_responder: RTL and testbench

//  DDR-side responder for the mem farm's DDR line-read request (mem_intf_read, DDR flavour).

---
 rtl/mannix_ddr_read_responder.sv | 120 ++++++++++++
 tb/tb_mannix_ddr_read_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mannix_ddr_read_responder.sv
// DDR line-read responder: fixed-latency line return from a preloadable store.
// Stands in for real DDR during block/system sim and FPGA bring-up.
module mannix_ddr_read_responder #(
  parameter int ADDR_WIDTH        = 32,
  parameter int WORD_WIDTH        = 256,
  parameter int NUM_WORDS_IN_LINE = 16,
  parameter int DEPTH             = 64,
  parameter int LATENCY           = 4,
  localparam int LINE_W     = NUM_WORDS_IN_LINE * WORD_WIDTH,
  localparam int LINE_BYTES = LINE_W / 8,
  localparam int OFF_W      = $clog2(LINE_BYTES),
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req,
  input  logic [ADDR_WIDTH-1:0] mem_start_addr,
  output logic                  mem_valid,
  output logic [LINE_W-1:0]     mem_data,
  output logic                  busy,
  output logic                  misaligned,
  output logic [15:0]           rd_count,
  input  logic                  ld_en,
  input  logic [IDX_W-1:0]      ld_idx,
  input  logic [LINE_W-1:0]     ld_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               mis_q, mis_d;
  logic [15:0]        rd_count_q, rd_count_d;
  logic [LINE_W-1:0]  mem_data_q, mem_data_d;
  logic [LINE_W-1:0]  store_q [DEPTH];

  // Only the index field matters; offset bits only feed the alignment flag
  // and bits above the index are dropped so the store wraps.
  logic unused_addr;
  assign unused_addr = ^mem_start_addr;

  // Preload port; blocked during reset, store contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && ld_en) begin
      store_q[ld_idx] <= ld_data;
    end
  end

  // Next-state, latency countdown, capture and counter update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    mis_d      = 1'b0;
    rd_count_d = rd_count_q;
    mem_data_d = mem_data_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          idx_d   = mem_start_addr[OFF_W +: IDX_W];
          cnt_d   = 8'(LATENCY - 1);
          mis_d   = |mem_start_addr[OFF_W-1:0];
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          mem_data_d = store_q[idx_q];
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rd_count_q != 16'hFFFF) begin
          rd_count_d = rd_count_q + 16'd1;
        end
        state_d = DONE;
      end
      DONE: begin
        if (!mem_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      idx_q      <= '0;
      mis_q      <= 1'b0;
      rd_count_q <= 16'd0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      mis_q      <= mis_d;
      rd_count_q <= rd_count_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign mem_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign misaligned = mis_q;
  assign rd_count   = rd_count_q;
  assign mem_data   = mem_data_q;

endmodule

// File: tb/tb_mannix_ddr_read_responder.sv
// Bench for mannix_ddr_read_responder: random reads against a line-store
// model that tracks indices, latency and response count arithmetically.
module tb_mannix_ddr_read_responder;

  localparam int AW    = 32;
  localparam int WW    = 256;
  localparam int NW    = 16;
  localparam int DEPTH = 64;
  localparam int LAT   = 4;
  localparam int LW    = NW * WW;
  localparam int LB    = LW / 8;
  localparam int IW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_req;
  logic [AW-1:0] mem_start_addr;
  logic          mem_valid;
  logic [LW-1:0] mem_data;
  logic          busy;
  logic          misaligned;
  logic [15:0]   rd_count;
  logic          ld_en;
  logic [IW-1:0] ld_idx;
  logic [LW-1:0] ld_data;

  logic [LW-1:0] model [DEPTH];
  int unsigned   model_cnt;
  int            checks;
  int            errors;

  mannix_ddr_read_responder #(
    .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .NUM_WORDS_IN_LINE(NW),
    .DEPTH(DEPTH), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req),
    .mem_start_addr(mem_start_addr), .mem_valid(mem_valid),
    .mem_data(mem_data), .busy(busy), .misaligned(misaligned),
    .rd_count(rd_count), .ld_en(ld_en), .ld_idx(ld_idx),
    .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'((longint'(a) / LB) % DEPTH);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [LW-1:0] d);
    ld_en  = 1'b1;
    ld_idx = IW'(idx);
    ld_data = d;
    step();
    ld_en = 1'b0;
    model[idx] = d;
  endtask

  // One full request: req at E0, valid expected after edge E0+LAT, held
  // 'hold' cycles past valid, optional early drop and preload on capture edge.
  task automatic do_read(input logic [AW-1:0] addr, input int hold,
                         input bit early, input bit ld_cap,
                         input logic [LW-1:0] ld_d, input string nm);
    int            id;
    int            nv;
    bit            exp_mis;
    logic [LW-1:0] exp;
    id      = idx_of(addr);
    exp     = model[id];
    exp_mis = (longint'(addr) % LB) != 0;
    nv      = 0;
    mem_req = 1'b1;
    mem_start_addr = addr;
    step();
    checks++;
    if (misaligned !== exp_mis || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s start: misaligned=%b busy=%b, required %b 1",
               nm, misaligned, busy, exp_mis);
    end
    mem_start_addr = $urandom;
    for (int n = 1; n <= LAT + hold; n++) begin
      if (early && n == 1) mem_req = 1'b0;
      if (ld_cap && n == LAT) begin
        ld_en   = 1'b1;
        ld_idx  = IW'(id);
        ld_data = ld_d;
      end
      step();
      if (ld_cap && n == LAT) begin
        ld_en = 1'b0;
        model[id] = ld_d;
      end
      if (n == 1) begin
        checks++;
        if (misaligned !== 1'b0) begin
          errors++;
          $display("FAIL %s mis_pulse: misaligned=%b, required 0",
                   nm, misaligned);
        end
      end
      if (mem_valid === 1'b1) begin
        nv++;
        checks++;
        if (n != LAT) begin
          errors++;
          $display("FAIL %s timing: valid at cycle %0d, required %0d",
                   nm, n, LAT);
        end
        checks++;
        if (mem_data !== exp) begin
          errors++;
          $display("FAIL %s data: low64=%h, required %h (idx %0d)",
                   nm, mem_data[63:0], exp[63:0], id);
        end
      end
    end
    checks++;
    if (nv != 1) begin
      errors++;
      $display("FAIL %s valid_count: %0d, required 1", nm, nv);
    end
    if (model_cnt != 32'hFFFF) model_cnt++;
    mem_req = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || rd_count !== 16'(model_cnt)) begin
      errors++;
      $display("FAIL %s end: busy=%b rd_count=%0d, required 0 %0d",
               nm, busy, rd_count, model_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_req = 1'b0;
    mem_start_addr = '0;
    ld_en = 1'b0;
    ld_idx = '0;
    ld_data = '0;
    step();
    step();
    rst = 1'b0;
    model_cnt = 0;
    checks++;
    if (mem_valid !== 1'b0 || busy !== 1'b0 || misaligned !== 1'b0 ||
        rd_count !== 16'd0 || mem_data !== '0) begin
      errors++;
      $display("FAIL reset: valid=%b busy=%b mis=%b cnt=%0d data0=%0d, required all 0",
               mem_valid, busy, misaligned, rd_count, (mem_data !== '0));
    end
    for (int i = 0; i < DEPTH; i++) load(i, rand_line());
  endtask

  task automatic test_basic();
    logic [LW-1:0] l;
    l = '0;
    l[0 +: WW]  = WW'(1);
    l[WW +: WW] = WW'(2);
    load(0, l);
    do_read(32'd0, 3, 1'b0, 1'b0, '0, "basic");
  endtask

  task automatic test_misaligned();
    do_read(32'd255, 20, 1'b0, 1'b0, '0, "misaligned_hold");
  endtask

  task automatic test_wrap();
    load(1, rand_line());
    do_read(32'(DEPTH * LB + LB), 2, 1'b0, 1'b0, '0, "wrap");
  endtask

  task automatic test_preload_collision();
    load(3, rand_line());
    do_read(32'(3 * LB), 2, 1'b0, 1'b1, rand_line(), "collide_old");
    do_read(32'(3 * LB), 2, 1'b0, 1'b0, '0, "collide_new");
  endtask

  task automatic test_reset_mid();
    mem_req = 1'b1;
    mem_start_addr = 32'(5 * LB);
    step();
    step();
    rst = 1'b1;
    mem_req = 1'b0;
    step();
    rst = 1'b0;
    model_cnt = 0;
    checks++;
    if (busy !== 1'b0 || rd_count !== 16'd0 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b cnt=%0d valid=%b, required 0 0 0",
               busy, rd_count, mem_valid);
    end
    for (int i = 0; i < LAT + 4; i++) begin
      step();
      checks++;
      if (mem_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_novalid: valid=%b at %0d, required 0",
                 mem_valid, i);
      end
    end
    do_read(32'(5 * LB), 1, 1'b0, 1'b0, '0, "after_reset");
  endtask

  task automatic test_back_to_back();
    do_read(32'(7 * LB + 4), 1, 1'b0, 1'b0, '0, "b2b_first");
    do_read(32'd512, 1, 1'b0, 1'b0, '0, "b2b_second");
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 1) load($urandom_range(0, DEPTH - 1), rand_line());
      do_read($urandom, $urandom_range(1, 5), bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 3) == 0), rand_line(), "random");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_misaligned();
    test_wrap();
    test_preload_collision();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
